// File: rtl/conv_shift_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_shift_acc_if
// Description : Slice-input and result-output handshake bundle for
//               conv_shift_acc.
//               Input side : in_valid/in_ready, four ADC partial sums
//                            (in_hh, in_hl, in_lh, in_ll) and in_addr.
//               Output side: out_valid/out_ready, out_data and out_addr.
//               modport slave  - used by conv_shift_acc
//               modport master - used by the producer/consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_shift_acc_if #(
    parameter int ADC_P = 4,
    parameter int AW    = 1,
    parameter int OUT_P = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [ADC_P-1:0] in_hh;
    logic [ADC_P-1:0] in_hl;
    logic [ADC_P-1:0] in_lh;
    logic [ADC_P-1:0] in_ll;
    logic [AW-1:0]    in_addr;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_P-1:0] out_data;
    logic [AW-1:0]    out_addr;

    modport slave (
        input  in_valid, in_hh, in_hl, in_lh, in_ll, in_addr, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );

    modport master (
        output in_valid, in_hh, in_hl, in_lh, in_ll, in_addr, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/conv_shift_acc.sv
`default_nettype none
// ============================================================================
// Module      : conv_shift_acc
// Description : Shift-and-accumulate stage behind the four-quadrant PIM conv
//               unit. Each accepted beat carries one input bit of both input
//               halves; the four ADC sums are weighted by their input/weight
//               half position, shifted by the bit index and accumulated over
//               INPUT_P/2 beats. The formatted result is then held on a
//               valid/ready output until taken.
// Ports       : clk - clock
//               rst - asynchronous active-low reset
//               clr - synchronous abort (highest priority)
//               bus - conv_shift_acc_if.slave (slice input + result output)
// Options     : CONV_SHIFT_ACC_SATURATE_EN - saturate out_data to all ones
//               instead of truncating when the shifted accumulator exceeds
//               OUT_P bits.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_shift_acc #(
    parameter int INPUT_P   = 8,
    parameter int W_P       = 8,
    parameter int ADC_P     = 4,
    parameter int DEPTH     = 1,
    parameter int OUT_P     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    conv_shift_acc_if.slave    bus
);
    localparam int c_ih    = INPUT_P / 2;
    localparam int c_wh    = W_P / 2;
    localparam int c_acc_w = ADC_P + INPUT_P + W_P;
    localparam int c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw    = (c_ih > 1) ? $clog2(c_ih) : 1;

    localparam logic [c_cw-1:0] c_last = c_cw'(c_ih - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_accum = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;

    logic [1:0]         r_state;
    logic [c_acc_w-1:0] r_acc;
    logic [c_cw-1:0]    r_bit_cnt;
    logic [c_aw-1:0]    r_addr;
    logic               r_out_valid;
    logic [OUT_P-1:0]   r_out_data;
    logic [c_aw-1:0]    r_out_addr;

    logic               w_in_ready;
    logic               w_beat;
    logic               w_last;
    logic [c_acc_w-1:0] w_slice;
    logic [c_acc_w-1:0] w_acc_base;
    logic [c_acc_w-1:0] w_acc_next;
    logic [c_acc_w-1:0] w_r;
    logic [OUT_P-1:0]   w_fmt;
    logic [c_aw-1:0]    w_addr_sel;

    // in_ready is gated by rst directly so it is low for the whole time
    // reset is asserted, not just after the first edge.
    assign w_in_ready = rst & (r_state != c_hold);
    assign w_beat     = bus.in_valid & w_in_ready;

    // bit_cnt is always 0 in IDLE, so with IH == 1 the first beat is also
    // the last one and IDLE goes straight to HOLD.
    assign w_last = (r_bit_cnt == c_last);

    assign w_slice = (c_acc_w'(bus.in_hh) << (c_ih + c_wh))
                   + (c_acc_w'(bus.in_hl) << c_ih)
                   + (c_acc_w'(bus.in_lh) << c_wh)
                   +  c_acc_w'(bus.in_ll);

    // The first beat of an accumulation overwrites rather than adds.
    assign w_acc_base = (r_state == c_idle) ? '0 : r_acc;
    assign w_acc_next = w_acc_base + (w_slice << r_bit_cnt);
    assign w_r        = w_acc_next >> OUT_SHIFT;

    // The address is taken from the first beat; when IH == 1 that beat is
    // also the last, so the live input is forwarded.
    assign w_addr_sel = (r_state == c_idle) ? bus.in_addr : r_addr;

    always_comb begin
        w_fmt = OUT_P'(w_r);
`ifdef CONV_SHIFT_ACC_SATURATE_EN
        if ((w_r >> OUT_P) != '0) begin
            w_fmt = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_idle;
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else if (clr) begin
            r_state     <= c_idle;
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            case (r_state)
                c_idle, c_accum: begin
                    if (w_beat) begin
                        r_acc <= w_acc_next;
                        if (r_state == c_idle) begin
                            r_addr <= bus.in_addr;
                        end
                        if (w_last) begin
                            r_state     <= c_hold;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_fmt;
                            r_out_addr  <= w_addr_sel;
                        end else begin
                            r_state   <= c_accum;
                            r_bit_cnt <= r_bit_cnt + c_cw'(1);
                        end
                    end
                end
                c_hold: begin
                    if (bus.out_ready) begin
                        r_state     <= c_idle;
                        r_acc       <= '0;
                        r_bit_cnt   <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
endmodule
`default_nettype wire

// File: tb/tb_conv_shift_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_shift_acc
// Description : Directed bench for conv_shift_acc with a result scoreboard.
//               Expected results are computed from the weighting formula and
//               queued as each accumulation is driven; they are popped and
//               compared when out_valid appears.
//               Honours CONV_SHIFT_ACC_SATURATE_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_shift_acc;
    localparam int INPUT_P   = 8;
    localparam int W_P       = 8;
    localparam int ADC_P     = 4;
    localparam int DEPTH     = 1;
    localparam int OUT_P     = 8;
    localparam int OUT_SHIFT = 0;
    localparam int IH        = INPUT_P / 2;
    localparam int WH        = W_P / 2;
    localparam int ACC_W     = ADC_P + INPUT_P + W_P;
    localparam int AW        = 1;

    typedef struct packed {
        logic [OUT_P-1:0] d;
        logic [AW-1:0]    a;
    } exp_t;

    logic clk;
    logic rst;
    logic clr;
    int   total;
    int   bad;
    exp_t exp_q[$];

    conv_shift_acc_if #(.ADC_P(ADC_P), .AW(AW), .OUT_P(OUT_P)) bus ();

    conv_shift_acc #(
        .INPUT_P  (INPUT_P),
        .W_P      (W_P),
        .ADC_P    (ADC_P),
        .DEPTH    (DEPTH),
        .OUT_P    (OUT_P),
        .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] slice_of(input logic [3:0] hh, input logic [3:0] hl,
                                                   input logic [3:0] lh, input logic [3:0] ll);
        logic [ACC_W-1:0] s;
        s = ACC_W'(hh) * (ACC_W'(1) << (IH + WH));
        s = s + ACC_W'(hl) * (ACC_W'(1) << IH);
        s = s + ACC_W'(lh) * (ACC_W'(1) << WH);
        s = s + ACC_W'(ll);
        return s;
    endfunction

    function automatic logic [OUT_P-1:0] fmt(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] r;
        r = acc >> OUT_SHIFT;
`ifdef CONV_SHIFT_ACC_SATURATE_EN
        if (r > ACC_W'((1 << OUT_P) - 1)) return {OUT_P{1'b1}};
`endif
        return r[OUT_P-1:0];
    endfunction

    // Present one beat and hold it until it is accepted (bounded wait).
    task automatic beat(input logic [3:0] hh, input logic [3:0] hl, input logic [3:0] lh,
                        input logic [3:0] ll, input logic [AW-1:0] a, input logic with_clr);
        int n;
        bus.in_hh = hh; bus.in_hl = hl; bus.in_lh = lh; bus.in_ll = ll;
        bus.in_addr = a; bus.in_valid = 1'b1; clr = with_clr;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("beat_accept_bound", 32'(n < 50), 32'd1);
        step();
        bus.in_valid = 1'b0;
        clr = 1'b0;
    endtask

    // Full accumulation: nibble k of each vector is beat k. Later beats carry
    // the inverted address so that only the first-beat address can come back.
    task automatic run4(input logic [15:0] hhv, input logic [15:0] hlv, input logic [15:0] lhv,
                        input logic [15:0] llv, input logic [AW-1:0] a0, input int gap);
        logic [ACC_W-1:0] acc;
        exp_t e;
        acc = '0;
        for (int k = 0; k < IH; k++)
            acc = acc + (slice_of(hhv[4*k +: 4], hlv[4*k +: 4], lhv[4*k +: 4], llv[4*k +: 4]) << k);
        e.d = fmt(acc);
        e.a = a0;
        exp_q.push_back(e);
        for (int k = 0; k < IH; k++) begin
            beat(hhv[4*k +: 4], hlv[4*k +: 4], lhv[4*k +: 4], llv[4*k +: 4],
                 (k == 0) ? a0 : ~a0, 1'b0);
            if (k != IH - 1) repeat (gap) step();
        end
    endtask

    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_valid_bound"}, 32'(bus.out_valid), 32'd1);
        if (bus.out_valid) begin
            chk({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_data"}, 32'(bus.out_data), 32'(e.d));
                chk({tag, "_addr"}, 32'(bus.out_addr), 32'(e.a));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clr   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_hh = '0; bus.in_hl = '0; bus.in_lh = '0; bus.in_ll = '0;
        bus.in_addr = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: ll = 1 on all beats -> 15, one-cycle latency, one-cycle pulse
        run4(16'h0000, 16'h0000, 16'h0000, 16'h1111, 1'b0, 0);
        chk("t1_latency_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_hold_in_ready", 32'(bus.in_ready), 32'd0);
        wait_result("t1");
        step();
        chk("t1_pulse_end", 32'(bus.out_valid), 32'd0);
        chk("t1_ready_again", 32'(bus.in_ready), 32'd1);

        // 2: lh = 1 on beat 0 -> 16, addr 0
        run4(16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b0, 0);
        wait_result("t2");
        step();

        // 3: hh = 1 on beat 0 -> 256: truncated or saturated; addr from beat 0
        run4(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 0);
        wait_result("t3");
        step();

        // 4: back-pressure for 5 cycles
        bus.out_ready = 1'b0;
        run4(16'h3A5F, 16'hC1E2, 16'h7D04, 16'hB69F, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_hold_data", 32'(bus.out_data), 32'(exp_q[0].d));
            chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("t4_hs_in_ready", 32'(bus.in_ready), 32'd0);
        wait_result("t4");
        step();
        chk("t4_after_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_after_hs_in_ready", 32'(bus.in_ready), 32'd1);

        // 5: asynchronous reset after two beats
        beat(4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0);
        beat(4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_async_out_data", 32'(bus.out_data), 32'd0);
        chk("t5_async_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        run4(16'h0000, 16'h0000, 16'h0000, 16'h2222, 1'b0, 0);
        wait_result("t5");
        step();

        // 6a: 3-cycle gaps between beats
        run4(16'h0000, 16'h2103, 16'h0A01, 16'h9F37, 1'b1, 3);
        wait_result("t6_gap");
        step();

        // 6b: clr together with beat 3 -> no result, then a clean run
        beat(4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        beat(4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        beat(4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        beat(4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("t6_clr_no_result", 32'(bus.out_valid), 32'd0);
            step();
        end
        run4(16'h0000, 16'h0000, 16'h0000, 16'h3141, 1'b1, 1);
        wait_result("t6_after_clr");
        step();

        // clr discards a held result
        bus.out_ready = 1'b0;
        run4(16'h0000, 16'h0000, 16'h0000, 16'h1111, 1'b0, 0);
        chk("clr_hold_valid", 32'(bus.out_valid), 32'd1);
        void'(exp_q.pop_front());
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_hold_dropped", 32'(bus.out_valid), 32'd0);
        chk("clr_hold_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;

        // Mixed quadrant values
        for (int i = 0; i < 4; i++) begin
            run4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            wait_result("mixed");
            step();
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
